// File: rtl/tdc_readout.sv
// tdc_readout: synchronises the tdc thermometer code, encodes it to a tap count
// and accumulates a batch of 2^AVG_LOG2 samples behind a valid/ready handshake.
module tdc_readout #(
  parameter int AVG_LOG2 = 4,
  localparam int RESULT_W = AVG_LOG2 + 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          term,
  input  logic                arm,
  output logic                busy,
  output logic [3:0]          code,
  output logic [RESULT_W-1:0] sum,
  output logic [AVG_LOG2:0]   sat_cnt,
  output logic                bubble,
  output logic                valid,
  input  logic                ready
);
  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;
  state_t                r_state, w_next;
  logic [7:0]            r_s1, r_s2;
  logic [3:0]            r_code;
  logic                  r_sat, r_bub;
  logic [AVG_LOG2-1:0]   r_cnt;
  logic [RESULT_W-1:0]   r_sum;
  logic [AVG_LOG2:0]     r_satc;
  logic                  r_bubble;
  logic                  w_last;
  logic                  w_bub;
  assign w_last = &r_cnt;
  assign w_bub  = |(r_s2[7:1] & ~r_s2[6:0]);
  // code, sat and bubble flags are registered together so each ACCUM add sees one coherent sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_code <= '0;
      r_sat  <= 1'b0;
      r_bub  <= 1'b0;
    end else begin
      r_s1   <= term;
      r_s2   <= r_s1;
      r_code <= 4'($countones(r_s2));
      r_sat  <= &r_s2;
      r_bub  <= w_bub;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = arm ? SETTLE : IDLE;
      SETTLE:  w_next = r_cnt[0] ? ACCUM : SETTLE;
      ACCUM:   w_next = w_last ? DONE : ACCUM;
      DONE:    w_next = ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy  = r_state != IDLE;
    valid = r_state == DONE;
  end
  // r_cnt counts the two SETTLE cycles, then the N ACCUM samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sum    <= '0;
      r_satc   <= '0;
      r_bubble <= 1'b0;
    end else if (r_state == IDLE && arm) begin
      r_cnt    <= '0;
      r_sum    <= '0;
      r_satc   <= '0;
      r_bubble <= 1'b0;
    end else if (r_state == SETTLE) begin
      r_cnt <= r_cnt[0] ? '0 : r_cnt + 1'b1;
    end else if (r_state == ACCUM) begin
      r_cnt    <= r_cnt + 1'b1;
      r_sum    <= r_sum + RESULT_W'(r_code);
      r_satc   <= r_satc + (AVG_LOG2+1)'(r_sat);
      r_bubble <= r_bubble | r_bub;
    end
  end
  assign code    = r_code;
  assign sum     = r_sum;
  assign sat_cnt = r_satc;
  assign bubble  = r_bubble;
endmodule

// File: doc/tdc_readout.md
# tdc_readout

Clocked capture and encoding stage sitting directly downstream of the `tdc` delay-line macro. It synchronises the 8-bit thermometer code (`term_0`..`term_7`), converts each sample to a 0..8 tap count, and accumulates a batch of 2^AVG_LOG2 samples into a sum, a saturation count and a bubble flag. The batch result is presented on a valid/ready interface to the host-facing logic.

## Interface
Parameters:
- AVG_LOG2, 4, log2 of the batch size N; legal range 1..6.
- RESULT_W, AVG_LOG2+4, width of the sum; derived, not overridden.

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  reset, asynchronous, active-low.
- term  input  8  raw thermometer code from `tdc`, asynchronous to clk. term[0] is the first tap.
- arm  input  1  single-cycle request to start one batch.
- busy  output  1  high from accepted arm until result handshake completes.
- code  output  4  tap count of the most recent synchronised sample, 0..8, updated every cycle.
- sum  output  RESULT_W  sum of N tap counts; held stable while valid.
- sat_cnt  output  AVG_LOG2+1  number of samples in the batch with term == 8'hFF.
- bubble  output  1  sticky for the batch: at least one sample was non-monotonic.
- valid  output  1  batch result available.
- ready  input  1  consumer accepts the result.

## Operation
- Synchroniser: two flops on all 8 bits (s1, s2). There is no clock-domain coherency guarantee across bits, so every sample is treated as possibly bubbled.
- Encode: code = popcount(s2), 0..8. This corrects bubbles by counting, not by searching for the first zero.
- Bubble detect: a sample is bubbled if any i in 0..6 has s2[i+1]=1 and s2[i]=0.
- Saturation: s2 == 8'hFF.

State machine:
- IDLE
  - Outputs: busy=0, valid=0.
  - Transition: arm=1 -> SETTLE. On that transition, sum, sat_cnt and bubble clear to 0 and the sample counter clears to 0.
- SETTLE
  - Lasts exactly 2 cycles so the synchroniser holds post-arm data.
  - Then -> ACCUM.
- ACCUM
  - One sample per cycle, for exactly N cycles.
  - Each cycle: sum += code, sat_cnt += sat, bubble |= bubbled, counter += 1.
  - When the counter reaches N-1 (its last add) -> DONE.
- DONE
  - Outputs: valid=1, busy=1. sum, sat_cnt and bubble are frozen.
  - valid && ready -> IDLE.

Width rules:
- sum max = 8*N, which fits RESULT_W with no overflow; no saturation logic.
- sat_cnt max = N, which fits AVG_LOG2+1.

Boundary conditions:
- arm while busy=1 (SETTLE, ACCUM or DONE) is ignored and not queued.
- arm and ready both high in DONE: the handshake completes, the block goes to IDLE, and arm is ignored.
- ready high while valid=0 has no effect.
- rst_n low at any time:
  - state goes to IDLE and every output goes to 0 (code=0, sum=0, sat_cnt=0, bubble=0, valid=0, busy=0);
  - synchroniser flops clear to 0;
  - a batch in progress is discarded.
- After leaving DONE, sum, sat_cnt and bubble keep their last values until the next arm is accepted.

## Timing
- term change to code: 3 cycles (s1, s2, then the registered code).
- arm sampled high at edge 0:
  - busy=1 after edge 0;
  - SETTLE spans edges 1..2;
  - ACCUM samples at edges 3..N+2;
  - valid=1 after edge N+2.
  - For N=16: first valid cycle is 19 cycles after arm.
- Handshake: valid falls on the cycle after the edge where valid && ready is seen, and busy falls with it. The earliest re-arm is accepted on the next edge.
- valid=1 is held indefinitely while ready=0. No output may change during that time except code.

## Test plan
- Reset mid-ACCUM, with arm and term=8'h0F driven and rst_n low for 1 cycle after 5 ACCUM samples: all outputs are 0 immediately (asynchronously); the block is in IDLE; a fresh arm then produces sum=64.
- Constant term=8'h0F, arm, ready=1, AVG_LOG2=4: valid after 19 cycles; sum=64, sat_cnt=0, bubble=0; code=4 throughout.
- term=8'hFF for the whole batch: sum=128, sat_cnt=16, bubble=0.
- term alternating 8'h07/8'h0B each cycle: code alternates 3/3; sum=48; bubble=1.
- Ready backpressure: hold ready=0 for 10 cycles after valid, pulse arm twice during that time, then ready=1:
  - valid stays 1 and sum stays stable until the handshake;
  - the arm pulses are ignored;
  - valid and busy fall the next cycle;
  - an arm on that following cycle is accepted.
- Sweep term through all 9 legal codes 8'h00, 8'h01 .. 8'hFF, holding each code for more than 3 cycles: code follows 0..8 with 3-cycle latency.
